// File: rtl/vram_write_ctrl_if.sv
// ---------------------------------------------------------------------------
// vram_write_ctrl_if
//
// Bundles the byte-intake handshake from uart_rx and the write port toward
// vram_24k, plus the status outputs of the decoder.
//
//   rx_data   [7:0]        byte from uart_rx, valid while rx_ready is high
//   rx_ready               uart_rx data_ready level
//   rx_ack                 one-cycle pulse per consumed byte
//   vram_we                one-cycle VRAM write strobe
//   vram_addr [ADDR_W-1:0] VRAM write address
//   vram_data [7:0]        VRAM write data
//   busy                   decoder is inside a frame or a fill
//   err                    one-cycle protocol-error pulse
//
// Modports: master = the decoder (vram_write_ctrl), slave = its environment.
// ---------------------------------------------------------------------------
interface vram_write_ctrl_if #(
  parameter int ADDR_W = 15
);
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              rx_ack;
  logic              vram_we;
  logic [ADDR_W-1:0] vram_addr;
  logic [7:0]        vram_data;
  logic              busy;
  logic              err;

  modport master (
    input  rx_data, rx_ready,
    output rx_ack, vram_we, vram_addr, vram_data, busy, err
  );

  modport slave (
    output rx_data, rx_ready,
    input  rx_ack, vram_we, vram_addr, vram_data, busy, err
  );
endinterface

// File: rtl/vram_write_ctrl.sv
// ---------------------------------------------------------------------------
// vram_write_ctrl
//
// Framed byte-stream decoder sitting between uart_rx and the user write port
// of vram_24k. Frames are: 0xA5, command, payload.
//   0x01 SET_ADDR : addr_hi, addr_lo        -> loads the write pointer
//   0x02 WRITE    : len_hi, len_lo, N bytes -> N writes with auto-increment
//   0x03 FILL     : len_hi, len_lo, value   -> N back-to-back writes of value
// The pointer wraps from VRAM_DEPTH-1 to 0 and persists across frames. An
// inter-byte timeout inside a frame aborts it with an err pulse.
//
// Ports:
//   clk    single clock for the whole block (pixel clock)
//   rst_n  asynchronous active-low reset
//   bus    vram_write_ctrl_if.master: rx_data/rx_ready in, rx_ack,
//          vram_we/vram_addr/vram_data, busy, err out (all registered)
//
// Build option: define VRAM_WR_FILL_EN to build the FILL command and its
// FILL_VAL / FILL_RUN states. Without it, 0x03 is an unknown command.
// ---------------------------------------------------------------------------
module vram_write_ctrl #(
  parameter int VRAM_DEPTH     = 22500,
  parameter int ADDR_W         = 15,
  parameter int TIMEOUT_CYCLES = 1066667
) (
  input  logic              clk,
  input  logic              rst_n,
  vram_write_ctrl_if.master bus
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_CMD      = 4'd1;
  localparam logic [3:0] S_ADDR_HI  = 4'd2;
  localparam logic [3:0] S_ADDR_LO  = 4'd3;
  localparam logic [3:0] S_LEN_HI   = 4'd4;
  localparam logic [3:0] S_LEN_LO   = 4'd5;
  localparam logic [3:0] S_DATA     = 4'd6;
`ifdef VRAM_WR_FILL_EN
  localparam logic [3:0] S_FILL_VAL = 4'd7;
  localparam logic [3:0] S_FILL_RUN = 4'd8;
`endif

  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(VRAM_DEPTH - 1);
  localparam logic [20:0]       TO_LAST  = 21'(TIMEOUT_CYCLES - 1);

  // State and datapath registers
  logic [3:0]        state_q, state_d;
  logic              rx_ready_q;
  logic              pending_q, pending_d;
  logic [7:0]        hi_q, hi_d;          // shared by addr_hi and len_hi
  logic [15:0]       len_q, len_d;        // writes still to perform
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [20:0]       to_cnt_q, to_cnt_d;
`ifdef VRAM_WR_FILL_EN
  logic              is_fill_q, is_fill_d;
  logic [7:0]        fill_val_q, fill_val_d;
`endif

  // Registered outputs
  logic              ack_q;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              err_q, err_d;
  logic              busy_q;

  logic              rx_edge;
  logic              consume;
  logic              timed;
  logic [7:0]        rx_byte;
  logic [15:0]       rx_word;

  function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign rx_byte = bus.rx_data;
  assign rx_word = {hi_q, bus.rx_data};
  assign rx_edge = bus.rx_ready & ~rx_ready_q;

  // A byte is taken whenever one is pending, except while a fill is
  // streaming: the fill owns the write port, so the byte waits in pending.
`ifdef VRAM_WR_FILL_EN
  assign consume = pending_q && (state_q != S_FILL_RUN);
  assign timed   = (state_q != S_IDLE) && (state_q != S_FILL_RUN);
`else
  assign consume = pending_q;
  assign timed   = (state_q != S_IDLE);
`endif

  // A new edge re-arms pending even on the cycle the previous byte is taken;
  // an edge while a byte is still waiting simply merges with it.
  assign pending_d = (pending_q & ~consume) | rx_edge;

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    len_d    = len_q;
    ptr_d    = ptr_q;
    to_cnt_d = to_cnt_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    err_d    = 1'b0;
`ifdef VRAM_WR_FILL_EN
    is_fill_d  = is_fill_q;
    fill_val_d = fill_val_q;
`endif

    if (consume) begin
      to_cnt_d = '0;
      case (state_q)
        S_IDLE: begin
          // Anything but a sync byte is line noise; drop it quietly.
          if (rx_byte == 8'hA5) state_d = S_CMD;
        end
        S_CMD: begin
          case (rx_byte)
            8'h01: state_d = S_ADDR_HI;
            8'h02: begin
`ifdef VRAM_WR_FILL_EN
              is_fill_d = 1'b0;
`endif
              state_d = S_LEN_HI;
            end
`ifdef VRAM_WR_FILL_EN
            8'h03: begin
              is_fill_d = 1'b1;
              state_d   = S_LEN_HI;
            end
`endif
            default: begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
          endcase
        end
        S_ADDR_HI: begin
          hi_d    = rx_byte;
          state_d = S_ADDR_LO;
        end
        S_ADDR_LO: begin
          if ({16'd0, rx_word} < 32'(VRAM_DEPTH)) ptr_d = rx_word[ADDR_W-1:0];
          else                                     err_d = 1'b1;
          state_d = S_IDLE;
        end
        S_LEN_HI: begin
          hi_d    = rx_byte;
          state_d = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_d = rx_word;
`ifdef VRAM_WR_FILL_EN
          if (is_fill_q) begin
            // The value byte is always expected, even for a zero length.
            state_d = S_FILL_VAL;
          end else
`endif
          if (rx_word == 16'd0) state_d = S_IDLE;
          else                  state_d = S_DATA;
        end
        S_DATA: begin
          we_d   = 1'b1;
          addr_d = ptr_q;
          data_d = rx_byte;
          ptr_d  = ptr_next(ptr_q);
          len_d  = len_q - 16'd1;
          if (len_q == 16'd1) state_d = S_IDLE;
        end
`ifdef VRAM_WR_FILL_EN
        S_FILL_VAL: begin
          fill_val_d = rx_byte;
          if (len_q == 16'd0) begin
            state_d = S_IDLE;
          end else begin
            // Issue the first fill write on the consume edge itself so the
            // strobe appears in the very next cycle; FILL_RUN does the rest.
            we_d    = 1'b1;
            addr_d  = ptr_q;
            data_d  = rx_byte;
            ptr_d   = ptr_next(ptr_q);
            len_d   = len_q - 16'd1;
            state_d = (len_q == 16'd1) ? S_IDLE : S_FILL_RUN;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
`ifdef VRAM_WR_FILL_EN
    end else if (state_q == S_FILL_RUN) begin
      we_d   = 1'b1;
      addr_d = ptr_q;
      data_d = fill_val_q;
      ptr_d  = ptr_next(ptr_q);
      len_d  = len_q - 16'd1;
      if (len_q == 16'd1) state_d = S_IDLE;
`endif
    end else if (timed) begin
      if (to_cnt_q == TO_LAST) begin
        err_d    = 1'b1;
        state_d  = S_IDLE;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 21'd1;
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rx_ready_q <= 1'b0;
      pending_q  <= 1'b0;
      hi_q       <= '0;
      len_q      <= '0;
      ptr_q      <= '0;
      to_cnt_q   <= '0;
`ifdef VRAM_WR_FILL_EN
      is_fill_q  <= 1'b0;
      fill_val_q <= '0;
`endif
      ack_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= bus.rx_ready;
      pending_q  <= pending_d;
      hi_q       <= hi_d;
      len_q      <= len_d;
      ptr_q      <= ptr_d;
      to_cnt_q   <= to_cnt_d;
`ifdef VRAM_WR_FILL_EN
      is_fill_q  <= is_fill_d;
      fill_val_q <= fill_val_d;
`endif
      ack_q      <= consume;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      err_q      <= err_d;
      busy_q     <= (state_d != S_IDLE);
    end
  end

  assign bus.rx_ack    = ack_q;
  assign bus.vram_we   = we_q;
  assign bus.vram_addr = addr_q;
  assign bus.vram_data = data_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_vram_write_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vram_write_ctrl
//
// Frame-level reference model: each frame task decides, from the command it
// is about to send, which VRAM writes and err pulses must follow and queues
// them. A monitor pops those expectations whenever the DUT strobes vram_we
// or err. Directed frames come first, then randomized frames. The timeout
// parameter is shortened so the silence case stays short.
// ---------------------------------------------------------------------------
module tb_vram_write_ctrl;
  localparam int DEPTH = 22500;
  localparam int TO    = 300;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vram_write_ctrl_if #(.ADDR_W(15)) bus ();

  vram_write_ctrl #(
    .VRAM_DEPTH    (DEPTH),
    .ADDR_W        (15),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [22:0] exp_wr_q[$];   // {addr, data}
  logic [7:0]  wdata[$];
  int exp_err      = 0;
  int m_ptr        = 0;
  int bytes_sent   = 0;
  int ack_cnt      = 0;
  int cyc          = 0;
  int last_we_cyc  = 0;
  int last_ack_cyc = 0;
  int we_run       = 0;
  int last_run     = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!rst_n) begin
      we_run = 0;
    end else begin
      if (bus.vram_we) begin
        we_run++;
        last_we_cyc = cyc;
        if (exp_wr_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL write: unexpected write addr=%0d data=0x%0h, expected none",
                   bus.vram_addr, bus.vram_data);
        end else begin
          logic [22:0] e;
          e = exp_wr_q.pop_front();
          chk($sformatf("write addr (exp %0d)", e[22:8]), {17'd0, bus.vram_addr}, {17'd0, e[22:8]});
          chk($sformatf("write data @%0d", e[22:8]), {24'd0, bus.vram_data}, {24'd0, e[7:0]});
        end
      end else if (we_run != 0) begin
        last_run = we_run;
        we_run   = 0;
      end
      if (bus.err) begin
        tests++;
        if (exp_err > 0) exp_err--;
        else begin
          fails++;
          $display("FAIL err: unexpected err pulse at cycle %0d, expected none", cyc);
        end
      end
      if (bus.rx_ack) begin
        ack_cnt++;
        last_ack_cyc = cyc;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_ready = 1'b1;
    bytes_sent++;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.rx_ack && n < 600);
    if (!bus.rx_ack) begin
      tests++;
      fails++;
      $display("FAIL ack_wait: byte 0x%0h got rx_ack=0 after %0d cycles, expected 1", b, n);
    end
    @(negedge clk);
    bus.rx_ready = 1'b0;
  endtask

  // Wait for the frame to finish, then every expectation must be consumed.
  task automatic settle(input string nm);
    int n;
    n = 0;
    while (bus.busy && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) begin @(posedge clk); #1; end
    chk({nm, " busy"}, {31'd0, bus.busy}, 32'd0);
    chk({nm, " writes left"}, exp_wr_q.size(), 32'd0);
    chk({nm, " err left"}, exp_err, 32'd0);
  endtask

  task automatic push_wr(input logic [7:0] d);
    exp_wr_q.push_back({15'(m_ptr), d});
    m_ptr = (m_ptr + 1) % DEPTH;
  endtask

  task automatic f_set(input int a);
    logic [15:0] a16;
    a16 = 16'(a);
    if (a < DEPTH) m_ptr = a;
    else           exp_err++;
    send_byte(8'hA5); send_byte(8'h01); send_byte(a16[15:8]); send_byte(a16[7:0]);
  endtask

  task automatic f_write();
    logic [15:0] n16;
    n16 = 16'(wdata.size());
    foreach (wdata[i]) push_wr(wdata[i]);
    send_byte(8'hA5); send_byte(8'h02); send_byte(n16[15:8]); send_byte(n16[7:0]);
    foreach (wdata[i]) send_byte(wdata[i]);
  endtask

  task automatic rand_wdata(input int n);
    wdata.delete();
    for (int i = 0; i < n; i++) wdata.push_back(8'($urandom));
  endtask

  task automatic f_fill(input int n, input logic [7:0] v);
    logic [15:0] n16;
    n16 = 16'(n);
    for (int i = 0; i < n; i++) push_wr(v);
    send_byte(8'hA5); send_byte(8'h03); send_byte(n16[15:8]); send_byte(n16[7:0]);
    send_byte(v);
  endtask

  task automatic f_bad(input logic [7:0] c);
    exp_err++;
    send_byte(8'hA5); send_byte(c);
  endtask

  task automatic f_stray(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      do b = 8'($urandom); while (b == 8'hA5);
      send_byte(b);
    end
  endtask

  function automatic bit valid_cmd(input logic [7:0] c);
`ifdef VRAM_WR_FILL_EN
    return (c == 8'h01) || (c == 8'h02) || (c == 8'h03);
`else
    return (c == 8'h01) || (c == 8'h02);
`endif
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    logic [7:0] c;
    bus.rx_data  = 8'h00;
    bus.rx_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset rx_ack",    {31'd0, bus.rx_ack},    32'd0);
    chk("reset vram_we",   {31'd0, bus.vram_we},   32'd0);
    chk("reset vram_addr", {17'd0, bus.vram_addr}, 32'd0);
    chk("reset vram_data", {24'd0, bus.vram_data}, 32'd0);
    chk("reset busy",      {31'd0, bus.busy},      32'd0);
    chk("reset err",       {31'd0, bus.err},       32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Set address then a two-byte write
    f_set(16'h0010);
    settle("set 0x0010");
    a0 = ack_cnt;
    wdata = '{8'h11, 8'h22};
    f_write();
    settle("write 11 22");
    chk("write 11 22 ack pulses", ack_cnt - a0, 32'd6);

    // Wrap at the top of memory, then an out-of-range address
    f_set(22499);
    wdata = '{8'hAA, 8'hBB};
    f_write();
    settle("wrap write");
    f_set(22500);
    settle("bad addr");
    wdata = '{8'h77};
    f_write();
    settle("ptr kept after bad addr");

    // Stray bytes, then an unknown command
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
    wdata = '{8'h5C};
    f_write();
    settle("stray then write");
    f_bad(8'h07);
    settle("bad cmd 07");

    // Zero-length write and a length with a non-zero high byte
    wdata.delete();
    f_write();
    settle("write len 0");
    rand_wdata(258);
    f_write();
    settle("write len 258");

`ifdef VRAM_WR_FILL_EN
    f_fill(5, 8'h3F);
    settle("fill 5");
    chk("fill 5 consecutive strobes", last_run, 32'd5);
    f_fill(0, 8'h99);
    settle("fill 0");
    f_fill(261, 8'h42);
    settle("fill 261");
    chk("fill 261 consecutive strobes", last_run, 32'd261);
    // A byte arriving while the fill streams waits until it has finished.
    f_fill(16, 8'hC3);
    send_byte(8'h00);
    settle("fill with byte mid-run");
    chk("mid-fill byte ack cycle", last_ack_cyc, last_we_cyc + 1);
`else
    f_bad(8'h03);
    settle("fill cmd disabled");
`endif

    // Inter-byte timeout after one of four data bytes
    exp_err++;
    push_wr(8'h01);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00); send_byte(8'h04);
    send_byte(8'h01);
    settle("timeout");
    rand_wdata(2);
    f_write();
    settle("after timeout");

    // Randomized frames
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 6))
        0: f_set($urandom_range(0, DEPTH - 1));
        1: f_set($urandom_range(DEPTH - 4, DEPTH - 1));
        2: f_set($urandom_range(DEPTH, 65535));
        3: begin rand_wdata($urandom_range(0, 6)); f_write(); end
`ifdef VRAM_WR_FILL_EN
        4: f_fill($urandom_range(0, 20), 8'($urandom));
`else
        4: begin rand_wdata($urandom_range(1, 3)); f_write(); end
`endif
        5: f_stray($urandom_range(1, 4));
        default: begin
          do c = 8'($urandom); while (valid_cmd(c));
          f_bad(c);
        end
      endcase
      settle($sformatf("random frame %0d", i));
    end

    // Reset in the middle of a running operation
`ifdef VRAM_WR_FILL_EN
    f_fill(50, 8'h5A);
    repeat (6) @(posedge clk);
`else
    wdata = '{8'h31, 8'h32};
    for (int i = 0; i < 2; i++) push_wr(wdata[i]);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'h31); send_byte(8'h32);
    repeat (2) @(posedge clk);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset vram_we", {31'd0, bus.vram_we}, 32'd0);
    chk("async reset busy",    {31'd0, bus.busy},    32'd0);
    exp_wr_q.delete();
    m_ptr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wdata = '{8'hE1};
    f_write();
    settle("write after reset");

    chk("total rx_ack pulses", ack_cnt, bytes_sent);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vram_write_ctrl.md
# vram_write_ctrl

Framed byte-stream decoder between `uart_rx` and the user port of `vram_24k`. It takes received bytes and turns framed commands into VRAM writes: set address, burst write with auto-increment, and optional fill. This replaces free-running "every byte goes to the next address" loading with addressable, resynchronisable updates. Runs entirely in the 106.67 MHz pixel clock domain.

## Interface
- `VRAM_DEPTH`, 22500: number of valid VRAM bytes; addresses wrap at `VRAM_DEPTH-1`.
- `ADDR_W`, 15: VRAM address width.
- `TIMEOUT_CYCLES`, 1066667: inter-byte timeout inside a frame (10 ms at 106.67 MHz); counter is 21 bits.
- `clk` in 1: system clock; one clock for the whole block.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rx_data` in 8: byte from `uart_rx`, valid while `rx_ready`=1.
- `rx_ready` in 1: `uart_rx` data_ready level.
- `rx_ack` out 1: one-cycle pulse when a byte is consumed.
- `vram_we` out 1: one-cycle write strobe to the VRAM user port.
- `vram_addr` out ADDR_W: write address.
- `vram_data` out 8: write data.
- `busy` out 1: high when not in IDLE.
- `err` out 1: one-cycle pulse on a protocol error.

## Operation
- Byte intake:
  - A rising edge of `rx_ready` (registered compare) sets `pending`.
  - A byte is consumed on a cycle where `pending`=1 and the state is not FILL_RUN. That cycle clears `pending`.
  - Edges occurring while `pending`=1 are not counted twice.
- Frame format: sync 0xA5, then a command byte, then a payload.
  - 0x01 SET_ADDR: addr_hi, addr_lo.
  - 0x02 WRITE: len_hi, len_lo, then N data bytes.
  - 0x03 FILL: len_hi, len_lo, value.
- States: IDLE, CMD, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, DATA, FILL_VAL, FILL_RUN.
- IDLE:
  - 0xA5 goes to CMD.
  - Any other byte is discarded silently (no `err`), state stays IDLE.
- CMD:
  - 0x01 goes to ADDR_HI.
  - 0x02 or 0x03 go to LEN_HI.
  - Any other value pulses `err` and returns to IDLE.
- SET_ADDR:
  - The 16-bit address is {hi, lo}.
  - If it is below VRAM_DEPTH, it loads the pointer `ptr`.
  - Otherwise `err` pulses and `ptr` is unchanged.
  - Either way the state returns to IDLE.
- WRITE:
  - The length N is {hi, lo}. N=0 returns to IDLE with no writes.
  - Each data byte produces one write at `ptr`, then `ptr` advances.
  - After the Nth byte the state returns to IDLE.
- FILL:
  - After the value byte, the block enters FILL_RUN: one write per clock at `ptr`, N writes in total, with `ptr` advancing each time.
  - Then IDLE. N=0 skips FILL_RUN.
- Pointer advance: `ptr` = VRAM_DEPTH-1 wraps to 0. Otherwise `ptr`+1. `ptr` persists across frames.
- Timeout:
  - The counter clears on every consumed byte and counts in CMD through FILL_VAL.
  - On reaching TIMEOUT_CYCLES-1: `err` pulses and the state goes to IDLE. `ptr` keeps the writes already done.
- Reset: all outputs go to 0, `ptr`=0, state IDLE, `pending`=0, counters 0. Reset mid-frame or mid-fill aborts immediately.

## Timing
- Consume at clock edge k: `rx_ack`=1 for the cycle after k.
- For a data byte, `vram_we`=1 in that same cycle, with `vram_addr`=old `ptr` and `vram_data`=byte. Latency is 1 clock from consume.
- FILL_RUN:
  - First write is in the cycle after the value byte is consumed.
  - `vram_we` stays high for exactly N consecutive cycles.
  - IDLE follows on the next cycle.
- `busy`, `err`, `vram_*` and `rx_ack` are registered outputs, never combinational.
- Simultaneous `rx_ready` edge and FILL_RUN: `pending` holds the byte. It is consumed on the first cycle after FILL_RUN ends.
- Throughput: one byte per `rx_ready` rising edge, with no back-pressure except during FILL_RUN.

## Configuration
- `VRAM_WR_FILL_EN`:
  - Defined: command 0x03 and the FILL_VAL and FILL_RUN states are built.
  - Undefined: 0x03 is treated as an unknown command (`err` pulse, IDLE), no fill logic is present, and `busy` is never high without a byte-driven state.

## Test plan
- Reset, then A5 01 00 10 → no writes, `ptr`=0x0010. Then A5 02 00 02 11 22 → writes (0x0010,0x11), (0x0011,0x22), `rx_ack` ×6 pulses.
- A5 01 57 E3 (addr 22499) then A5 02 00 02 AA BB → writes at 22499 then 0. Separately, A5 01 57 E4 → `err` pulse, `ptr` unchanged.
- Stray bytes 00 FF 12 before A5 02 00 01 5C → no `err`, single write 0x5C at current `ptr`. Also A5 07 → `err` pulse, back to IDLE.
- With VRAM_WR_FILL_EN defined: A5 03 00 05 3F → `vram_we` high 5 consecutive cycles, data 0x3F, addresses `ptr`..`ptr`+4. A byte arriving mid-fill is acked after the fill completes.
- A5 02 00 04 01, then silence of TIMEOUT_CYCLES → one write, `err` pulse, `busy` low. The next A5 frame decodes normally.
- Assert `rst_n`=0 during FILL_RUN → `vram_we`, `busy` drop to 0 asynchronously, `ptr`=0 after release.
